i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Audio sink stage downstream of the control block's input path.
- Pops PCM bytes from the input async FIFO read port and assembles 24-bit stereo frames.
- Serializes frames as Philips I2S toward the DAC.
- Runs on the audio master clock (24.576 MHz for the 48 kHz family, 22.5792 MHz for the 44.1 kHz family); one instance per selected clock.

Parameters:
- BCLK_DIV, 8, clk_i cycles per BCLK period; even, >=4. 8 gives 64*Fs at either master clock.
- SAMPLE_BITS, 24, significant bits per channel; fixed 3 bytes/channel, 6 bytes/frame.
- SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS.

Ports:
- clk_i  in  1  audio master clock
- reset_n_i  in  1  reset; asynchronous, active-low
- rd_fifo_clk_o  out  1  FIFO read clock, = clk_i
- rd_fifo_en_o  out  1  FIFO pop strobe
- rd_fifo_empty_i  in  1  FIFO empty flag
- rd_fifo_data_i  in  8  FIFO read data, valid the cycle after rd_fifo_en_o
- i2s_bclk_o  out  1  bit clock
- i2s_lrck_o  out  1  word select: 0 = left, 1 = right
- i2s_sdata_o  out  1  serial data, MSB first
- frame_tick_o  out  1  one-cycle pulse on each frame load
- underrun_o  out  1  sticky underrun flag

Behaviour:
- Reset (reset_n_i low, async): all outputs 0; counters 0; staging and shift registers cleared; pending bytes discarded. Outputs come up silent after release. Reset mid-frame truncates the frame immediately.
- Divider: div_cnt 0..BCLK_DIV-1.
  - i2s_bclk_o = 0 for div_cnt < BCLK_DIV/2, 1 otherwise.
  - Wrap to 0 is the BCLK falling edge. bit_cnt (0..2*SLOT_BITS-1) advances on each wrap. lrck and sdata update only on wraps; DAC samples on the rising edge.
- Slot map for bit_cnt n:
  - i2s_lrck_o = 0 for n < SLOT_BITS, 1 otherwise.
  - sdata = L[23..0] for n = 1..24.
  - sdata = R[23..0] for n = SLOT_BITS+1..SLOT_BITS+24.
  - All other n (including the I2S delay bit at n=0 and n=SLOT_BITS) = 0.
- Assembler: byte_cnt 0..6 counts captured plus in-flight bytes.
  - rd_fifo_en_o = 1 when !rd_fifo_empty_i and byte_cnt < 6. Back-to-back pops are allowed.
  - Data is captured the cycle after each pop.
  - Byte order: L[7:0], L[15:8], L[23:16], R[7:0], R[15:8], R[23:16].
- Frame boundary is the wrap into n=0:
  - byte_cnt == 6 and captures complete: staging moves to the shift register, byte_cnt <= 0, frame_tick_o pulses once.
  - Otherwise: underrun. underrun_o <= 1 (cleared only by reset). A silent frame is output. Partial staging bytes are kept so byte alignment is preserved.
- A pop cannot coincide with a transfer, because byte_cnt == 6 blocks pops.
- Latency: a complete frame in staging appears at the next boundary; its left MSB is driven one BCLK later (n=1).
- Empty FIFO: no pop, no error until the boundary check.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the shift register reloads the previous frame's L/R, so the last sample is held. After reset with no prior frame, the repeated frame is 0.
- Undefined: underrun frames are all zero.
- underrun_o and frame_tick_o behave identically in both builds; frame_tick_o does not pulse on underrun.

Test Plan:
- Reset: hold reset_n_i low for 5 clk, then release -> all outputs 0. First BCLK rising edge at clk 4 after release with BCLK_DIV=8.
- Single frame: push bytes 56 34 12 EF CD AB before the first boundary -> 6 pops, frame_tick_o once. Left slot bits n=1..24 = 0x123456, right slot = 0xABCDEF, remaining bits 0, underrun_o stays 0.
- Empty FIFO for 2 frames -> sdata constantly 0, underrun_o = 1 after the first boundary, no rd_fifo_en_o. Repeat build: also 0.
- Partial fill: 3 bytes (AA BB CC) before a boundary, remaining 3 (11 22 33) after it -> first boundary underruns. Next frame L = 0xCCBBAA, R = 0x332211.
- Streaming: 30 bytes preloaded -> exactly 5 frame_tick_o pulses spaced 512 clk apart, 30 pops, no underrun. Repeat build, then FIFO drained: frame 6 repeats frame 5.
- Reset asserted at bit_cnt=10 of a loaded frame -> outputs 0 asynchronously. After release, the first boundary is an underrun; the previous frame is not resumed.

Source files
------------

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx : Philips I2S transmitter fed from a byte-wide FIFO read port.
//
// Pops PCM bytes (L[7:0], L[15:8], L[23:16], R[7:0], R[15:8], R[23:16]) into
// a staging register. At every frame boundary it moves a complete frame into
// the output shift register. If the frame is not complete, it flags an
// underrun and sends a silent (or repeated) frame. The frame is serialised
// MSB first. The data lags LRCK by one BCLK, as the I2S format requires.
//
// Ports
//   clk_i            audio master clock
//   reset_n_i        asynchronous active-low reset
//   rd_fifo_clk_o    FIFO read clock (copy of clk_i)
//   rd_fifo_en_o     FIFO pop strobe; data is valid the following cycle
//   rd_fifo_empty_i  FIFO empty flag
//   rd_fifo_data_i   FIFO read data (8 bit)
//   i2s_bclk_o       bit clock, clk_i / BCLK_DIV
//   i2s_lrck_o       word select, 0 = left, 1 = right
//   i2s_sdata_o      serial data, changes on BCLK falling edge
//   frame_tick_o     one-cycle pulse when a staged frame is loaded
//   underrun_o       sticky underrun flag, cleared only by reset
//
// Optional build macro: I2S_TX_UNDERRUN_REPEAT_EN
//   defined   -> an underrun frame repeats the last loaded frame (zero after
//                reset)
//   undefined -> an underrun frame is all zero
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int BCLK_DIV    = 8,   // clk_i cycles per BCLK, even, >= 4
  parameter int SAMPLE_BITS = 24,  // significant bits per channel (3 bytes)
  parameter int SLOT_BITS   = 32   // BCLK periods per channel slot
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  output logic       rd_fifo_clk_o,
  output logic       rd_fifo_en_o,
  input  logic       rd_fifo_empty_i,
  input  logic [7:0] rd_fifo_data_i,
  output logic       i2s_bclk_o,
  output logic       i2s_lrck_o,
  output logic       i2s_sdata_o,
  output logic       frame_tick_o,
  output logic       underrun_o
);

  localparam int DIV_W        = $clog2(BCLK_DIV);
  localparam int BIT_W        = $clog2(2 * SLOT_BITS);
  localparam int BYTES_PER_CH = 3;
  localparam int FRAME_BYTES  = 2 * BYTES_PER_CH;
  localparam int FRAME_W      = 2 * SAMPLE_BITS;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] R_START    = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] L_FIRST    = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST     = BIT_W'(SAMPLE_BITS);
  localparam logic [BIT_W-1:0] R_FIRST    = BIT_W'(SLOT_BITS + 1);
  localparam logic [BIT_W-1:0] R_LAST     = BIT_W'(SLOT_BITS + SAMPLE_BITS);
  localparam logic [2:0]       BYTES_FULL = 3'(FRAME_BYTES);

  // Timing state
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BIT_W-1:0]   bit_nxt;
  logic               wrap;
  logic               boundary;

  // Assembler state
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic               pop;
  logic               pop_q;
  logic [2:0]         pop_idx_q;
  logic [FRAME_W-1:0] stage_frame;
  logic               frame_ok;

  // Serializer state
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] underrun_frame;
  logic               sdata_q, sdata_d;
  logic               lrck_q, lrck_d;
  logic               tick_q, tick_d;
  logic               underrun_q, underrun_d;

  assign wrap     = (div_cnt_q == DIV_LAST);
  assign bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
  assign boundary = wrap && (bit_nxt == '0);

  // byte_cnt counts bytes already popped, including the one still in flight.
  // So a frame is usable only after that last capture has landed.
  assign frame_ok = (byte_cnt_q == BYTES_FULL) && !pop_q;

  // Gated by reset so the strobe is silent while reset is held.
  assign pop = reset_n_i && !rd_fifo_empty_i && (byte_cnt_q < BYTES_FULL);

  // Staging bytes. Byte k of the stream lands in its fixed place in the
  // {L, R} frame word. Left bytes go to the upper half, LSB byte first.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_BYTES; gi = gi + 1) begin : g_stage
      localparam int LSB = (gi < BYTES_PER_CH) ? SAMPLE_BITS + 8 * gi
                                               : 8 * (gi - BYTES_PER_CH);
      logic [7:0] byte_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          byte_q <= '0;
        end else if (pop_q && (pop_idx_q == 3'(gi))) begin
          byte_q <= rd_fifo_data_i;
        end
      end

      assign stage_frame[LSB +: 8] = byte_q;
    end
  endgenerate

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  // Copy of the last frame that was actually loaded, replayed on underrun.
  logic [FRAME_W-1:0] last_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= '0;
    end else if (boundary && frame_ok) begin
      last_q <= stage_frame;
    end
  end

  assign underrun_frame = last_q;
`else
  assign underrun_frame = '0;
`endif

  always_comb begin
    div_cnt_d  = wrap ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    sdata_d    = sdata_q;
    lrck_d     = lrck_q;
    tick_d     = 1'b0;
    underrun_d = underrun_q;

    if (pop) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end

    // The wrap is the BCLK falling edge. LRCK and data change only here.
    if (wrap) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = (bit_nxt >= R_START);
      sdata_d   = 1'b0;
      if (boundary) begin
        if (frame_ok) begin
          shift_d    = stage_frame;
          byte_cnt_d = '0;
          tick_d     = 1'b1;
        end else begin
          // Partial staging is kept so the byte alignment of the stream
          // survives the underrun.
          shift_d    = underrun_frame;
          underrun_d = 1'b1;
        end
      end else if (((bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST)) ||
                   ((bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST))) begin
        // Left then right are contiguous in the shift word. After 24 left
        // shifts, R[23] sits at the top, ready for the right slot.
        sdata_d = shift_q[FRAME_W-1];
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pop_q      <= 1'b0;
      pop_idx_q  <= '0;
      shift_q    <= '0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pop_q      <= pop;
      if (pop) begin
        pop_idx_q <= byte_cnt_q;
      end
      shift_q    <= shift_d;
      sdata_q    <= sdata_d;
      lrck_q     <= lrck_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign rd_fifo_clk_o = clk_i;
  assign rd_fifo_en_o  = pop;
  assign i2s_bclk_o    = (div_cnt_q >= DIV_HALF);
  assign i2s_lrck_o    = lrck_q;
  assign i2s_sdata_o   = sdata_q;
  assign frame_tick_o  = tick_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx : self-checking bench for i2s_tx (BCLK_DIV=8, 24/32 bit slots).
// A queue models the FIFO. A receiver rebuilds each 64-bit I2S frame from
// the BCLK rising edges and checks it against a queue of expected frames.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       rd_fifo_clk_o;
  logic       rd_fifo_en_o;
  logic       rd_fifo_empty_i;
  logic [7:0] rd_fifo_data_i;
  logic       i2s_bclk_o;
  logic       i2s_lrck_o;
  logic       i2s_sdata_o;
  logic       frame_tick_o;
  logic       underrun_o;

  i2s_tx #(
    .BCLK_DIV   (8),
    .SAMPLE_BITS(24),
    .SLOT_BITS  (32)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .rd_fifo_clk_o  (rd_fifo_clk_o),
    .rd_fifo_en_o   (rd_fifo_en_o),
    .rd_fifo_empty_i(rd_fifo_empty_i),
    .rd_fifo_data_i (rd_fifo_data_i),
    .i2s_bclk_o     (i2s_bclk_o),
    .i2s_lrck_o     (i2s_lrck_o),
    .i2s_sdata_o    (i2s_sdata_o),
    .frame_tick_o   (frame_tick_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  typedef struct packed {
    logic [47:0] bytes;   // stream order, first byte in [47:40]
    logic [23:0] l;
    logic [23:0] r;
  } vec_t;

  vec_t       tbl [5];
  frame_t     exp_q [$];
  logic [7:0] fifo_q [$];
  int         tick_cyc [$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          pops;
  int          ticks;
  int          rise_cnt;
  logic        bclk_prev;
  logic        sdata_hi;
  logic [63:0] fb;
  logic [63:0] lb;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_frame(input int idx);
    logic [23:0] gl;
    logic [23:0] gr;
    int          extra;
    int          lrerr;
    frame_t      e;
    gl    = '0;
    gr    = '0;
    extra = 0;
    lrerr = 0;
    for (int n = 1; n <= 24; n++) gl = {gl[22:0], fb[n]};
    for (int n = 33; n <= 56; n++) gr = {gr[22:0], fb[n]};
    for (int n = 0; n < 64; n++) begin
      if (!((n >= 1 && n <= 24) || (n >= 33 && n <= 56)) && fb[n]) extra++;
      if (lb[n] !== (n >= 32)) lrerr++;
    end
    $display("frame %0d: L=%06h R=%06h", idx, gl, gr);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame%0d_unexpected: frame received with no expectation queued", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("frame%0d_left", idx), int'(gl), int'(e.l));
      chk($sformatf("frame%0d_right", idx), int'(gr), int'(e.r));
      chk($sformatf("frame%0d_pad_bits_set", idx), extra, 0);
      chk($sformatf("frame%0d_lrck_errors", idx), lrerr, 0);
    end
  endtask

  // One clock: FIFO pop model, then output monitor at posedge + 1.
  task automatic step();
    logic en_pre;
    @(negedge clk);
    en_pre = rd_fifo_en_o;
    @(posedge clk);
    #1;
    cyc++;
    if (en_pre) begin
      pops++;
      if (fifo_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_on_empty: pop at cycle %0d with empty FIFO", cyc);
      end else begin
        rd_fifo_data_i = fifo_q.pop_front();
      end
    end
    rd_fifo_empty_i = (fifo_q.size() == 0);
    if (frame_tick_o) begin
      ticks++;
      tick_cyc.push_back(cyc);
    end
    if (i2s_sdata_o) sdata_hi = 1'b1;
    if (i2s_bclk_o && !bclk_prev) begin
      fb[rise_cnt % 64] = i2s_sdata_o;
      lb[rise_cnt % 64] = i2s_lrck_o;
      if ((rise_cnt % 64) == 63) check_frame(rise_cnt / 64);
      rise_cnt++;
    end
    bclk_prev = i2s_bclk_o;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    rd_fifo_empty_i = 1'b0;
  endtask

  task automatic push_bytes(input logic [47:0] b);
    for (int k = 0; k < 6; k++) push_byte(b[47-8*k -: 8]);
  endtask

  // Asserted asynchronously at the current time, held 5 clocks, and
  // released just after a rising edge. cyc counts edges after release.
  task automatic apply_reset(input string tag);
    reset_n_i = 1'b0;
    #1;
    $display("reset %s asserted", tag);
    chk({tag, "_rst_bclk"}, int'(i2s_bclk_o), 0);
    chk({tag, "_rst_lrck"}, int'(i2s_lrck_o), 0);
    chk({tag, "_rst_sdata"}, int'(i2s_sdata_o), 0);
    chk({tag, "_rst_tick"}, int'(frame_tick_o), 0);
    chk({tag, "_rst_underrun"}, int'(underrun_o), 0);
    chk({tag, "_rst_fifo_en"}, int'(rd_fifo_en_o), 0);
    repeat (5) @(posedge clk);
    #1;
    fifo_q.delete();
    exp_q.delete();
    tick_cyc.delete();
    rd_fifo_empty_i = 1'b1;
    rd_fifo_data_i  = '0;
    cyc       = 0;
    pops      = 0;
    ticks     = 0;
    rise_cnt  = 0;
    bclk_prev = 1'b0;
    sdata_hi  = 1'b0;
    reset_n_i = 1'b1;
  endtask

  initial begin
    tbl[0] = {48'h563412EFCDAB, 24'h123456, 24'hABCDEF};
    tbl[1] = {48'h010203040506, 24'h030201, 24'h060504};
    tbl[2] = {48'hFF00807FFF01, 24'h8000FF, 24'h01FF7F};
    tbl[3] = {48'h112233445566, 24'h332211, 24'h665544};
    tbl[4] = {48'hA55AC33C9669, 24'hC35AA5, 24'h69963C};

    reset_n_i       = 1'b1;
    rd_fifo_empty_i = 1'b1;
    rd_fifo_data_i  = '0;
    cyc             = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset and empty FIFO for the first frames
    apply_reset("a");
    repeat (3) exp_q.push_back('0);
    run_until(3);
    chk("bclk_low_at_clk3", int'(i2s_bclk_o), 0);
    run_until(4);
    chk("bclk_first_rise_clk4", int'(i2s_bclk_o), 1);
    chk("fifo_clk_follows_clk", int'(rd_fifo_clk_o), int'(clk));
    run_until(511);
    chk("a_underrun_before_boundary", int'(underrun_o), 0);
    run_until(512);
    chk("a_underrun_at_boundary", int'(underrun_o), 1);
    run_until(1535);
    chk("a_pops", pops, 0);
    chk("a_ticks", ticks, 0);
    chk("a_sdata_ever_high", int'(sdata_hi), 0);
    chk("a_underrun_sticky", int'(underrun_o), 1);
    chk("a_frames_pending", exp_q.size(), 0);

    // Single frame loaded before the first boundary
    apply_reset("b");
    exp_q.push_back('0);
    exp_q.push_back(frame_t'({tbl[0].l, tbl[0].r}));
    run_until(4);
    push_bytes(tbl[0].bytes);
    run_until(1020);
    chk("b_pops", pops, 6);
    chk("b_ticks", ticks, 1);
    chk("b_tick_cycle", (ticks > 0) ? tick_cyc[0] : -1, 512);
    chk("b_underrun", int'(underrun_o), 0);
    chk("b_frames_pending", exp_q.size(), 0);

    // Partial fill across a boundary
    apply_reset("c");
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back(frame_t'({24'hCCBBAA, 24'h332211}));
    run_until(4);
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hCC);
    run_until(511);
    chk("c_underrun_before_boundary", int'(underrun_o), 0);
    run_until(512);
    chk("c_underrun_partial", int'(underrun_o), 1);
    chk("c_pops_first", pops, 3);
    run_until(520);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    run_until(1535);
    chk("c_ticks", ticks, 1);
    chk("c_tick_cycle", (ticks > 0) ? tick_cyc[0] : -1, 1024);
    chk("c_pops_total", pops, 6);
    chk("c_frames_pending", exp_q.size(), 0);

    // Streaming from the vector table, then drained
    apply_reset("d");
    exp_q.push_back('0);
    for (int i = 0; i < 5; i++) exp_q.push_back(frame_t'({tbl[i].l, tbl[i].r}));
    exp_q.push_back(REPEAT ? frame_t'({tbl[4].l, tbl[4].r}) : frame_t'('0));
    run_until(4);
    for (int i = 0; i < 5; i++) push_bytes(tbl[i].bytes);
    run_until(3071);
    chk("d_underrun_while_streaming", int'(underrun_o), 0);
    chk("d_pops", pops, 30);
    run_until(3072);
    chk("d_underrun_after_drain", int'(underrun_o), 1);
    run_until(3583);
    chk("d_ticks", ticks, 5);
    chk("d_first_tick", (ticks > 0) ? tick_cyc[0] : -1, 512);
    for (int i = 1; i < tick_cyc.size(); i++)
      chk($sformatf("d_tick_spacing%0d", i), tick_cyc[i] - tick_cyc[i-1], 512);
    chk("d_frames_pending", exp_q.size(), 0);

    // Reset in the middle of a loaded frame
    apply_reset("e");
    exp_q.push_back('0);
    exp_q.push_back(frame_t'({24'hFFFFFF, 24'h000000}));
    run_until(4);
    push_bytes(48'hFFFFFF000000);
    run_until(597);  // bit_cnt = 10 of frame 1, BCLK high
    chk("e_sdata_before_reset", int'(i2s_sdata_o), 1);
    chk("e_bclk_before_reset", int'(i2s_bclk_o), 1);
    apply_reset("e_mid");
    exp_q.push_back('0);
    exp_q.push_back('0);
    run_until(511);
    chk("e_underrun_before_boundary", int'(underrun_o), 0);
    run_until(512);
    chk("e_underrun_after_reset", int'(underrun_o), 1);
    run_until(1023);
    chk("e_ticks", ticks, 0);
    chk("e_pops", pops, 0);
    chk("e_sdata_ever_high", int'(sdata_hi), 0);
    chk("e_frames_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
